// File: rtl/rv_db_split.sv
// rtl/rv_db_split.sv - RV32 load/store unit to Wishbone-classic with misaligned split, bus error and timeout
module rv_db_split #(
    parameter int SPLIT_MISALIGN = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        cmd_dbus_i,
    input  logic        cmd_dbus_store_i,
    input  logic        cmd_dbus_byte_i,
    input  logic        cmd_dbus_hword_i,
    input  logic        cmd_signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        we_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    output logic        dbus_we_o,
    output logic [3:0]  dbus_sel_o,
    output logic [29:0] dbus_adr_o,
    output logic [31:0] dbus_dat_o,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i,
    input  logic [31:0] dbus_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] tcnt;

    // Captured request attributes, held for the whole access
    logic        store_q;
    logic        byte_q;
    logic        hword_q;
    logic        sgn_q;
    logic        split_q;
    logic [1:0]  off_q;
    logic [3:0]  sel1_q;
    logic [31:0] dat1_q;
    logic [31:0] beat0_q;

    // Request decode: lane masks and shifted data for both beats
    logic [1:0]  req_off;
    logic [3:0]  req_mask;
    logic        req_cross;
    logic [7:0]  req_sel_w;
    logic [63:0] req_dat_w;

    // Load data assembly
    logic [4:0]  ld_sh;
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;

    assign busy_o = (state != IDLE) | we_o;

    // Decode the incoming request; upper halves of the wide shifts form the second beat
    always_comb begin
        req_off   = addr_i[1:0];
        req_mask  = 4'b1111;
        req_cross = (req_off != 2'd0);
        if (cmd_dbus_byte_i) begin
            req_mask  = 4'b0001;
            req_cross = 1'b0;
        end else if (cmd_dbus_hword_i) begin
            req_mask  = 4'b0011;
            req_cross = (req_off == 2'd3);
        end
        req_sel_w = {4'b0000, req_mask} << req_off;
        req_dat_w = {32'h0000_0000, wdata_i} << {req_off, 3'b000};
    end

    // Align returned data to bit 0, merging both beats of a split, then extend
    always_comb begin
        ld_sh = {off_q, 3'b000};
        if (split_q) begin
            ld_raw = 32'({dbus_dat_i, beat0_q} >> ld_sh);
        end else begin
            ld_raw = dbus_dat_i >> ld_sh;
        end
        if (byte_q) begin
            ld_ext = {{24{sgn_q & ld_raw[7]}}, ld_raw[7:0]};
        end else if (hword_q) begin
            ld_ext = {{16{sgn_q & ld_raw[15]}}, ld_raw[15:0]};
        end else begin
            ld_ext = ld_raw;
        end
    end

    // Access sequencer: capture, one or two locked beats, completion/abort with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tcnt       <= 16'd0;
            store_q    <= 1'b0;
            byte_q     <= 1'b0;
            hword_q    <= 1'b0;
            sgn_q      <= 1'b0;
            split_q    <= 1'b0;
            off_q      <= 2'd0;
            sel1_q     <= 4'd0;
            dat1_q     <= 32'd0;
            beat0_q    <= 32'd0;
            rdata_o    <= 32'd0;
            we_o       <= 1'b0;
            misalign_o <= 1'b0;
            fault_o    <= 1'b0;
            dbus_cyc_o <= 1'b0;
            dbus_stb_o <= 1'b0;
            dbus_we_o  <= 1'b0;
            dbus_sel_o <= 4'd0;
            dbus_adr_o <= 30'd0;
            dbus_dat_o <= 32'd0;
        end else begin
            we_o       <= 1'b0;
            misalign_o <= 1'b0;
            fault_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && cmd_dbus_i) begin
                        store_q <= cmd_dbus_store_i;
                        byte_q  <= cmd_dbus_byte_i;
                        hword_q <= cmd_dbus_hword_i & ~cmd_dbus_byte_i;
                        sgn_q   <= cmd_signed_i;
                        split_q <= req_cross;
                        off_q   <= req_off;
                        sel1_q  <= req_sel_w[7:4];
                        dat1_q  <= req_dat_w[63:32];
                        if (req_cross && (SPLIT_MISALIGN == 0)) begin
                            misalign_o <= 1'b1;
                        end else begin
                            dbus_cyc_o <= 1'b1;
                            dbus_stb_o <= 1'b1;
                            dbus_we_o  <= cmd_dbus_store_i;
                            dbus_adr_o <= addr_i[31:2];
                            dbus_sel_o <= req_sel_w[3:0];
                            dbus_dat_o <= req_dat_w[31:0];
                            tcnt       <= 16'd0;
                            state      <= BEAT0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (dbus_err_i) begin
                        dbus_cyc_o <= 1'b0;
                        dbus_stb_o <= 1'b0;
                        fault_o    <= 1'b1;
                        state      <= IDLE;
                    end else if (dbus_ack_i) begin
                        if ((state == BEAT0) && split_q) begin
                            // Bus stays locked: cyc/stb held high into the second beat
                            beat0_q    <= dbus_dat_i;
                            dbus_adr_o <= dbus_adr_o + 30'd1;
                            dbus_sel_o <= sel1_q;
                            dbus_dat_o <= dat1_q;
                            tcnt       <= 16'd0;
                            state      <= BEAT1;
                        end else begin
                            dbus_cyc_o <= 1'b0;
                            dbus_stb_o <= 1'b0;
                            state      <= IDLE;
                            if (!store_q) begin
                                rdata_o <= ld_ext;
                                we_o    <= 1'b1;
                            end
                        end
                    end else if (TO_EN && (tcnt == TO_LAST)) begin
                        dbus_cyc_o <= 1'b0;
                        dbus_stb_o <= 1'b0;
                        fault_o    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: begin
                    dbus_cyc_o <= 1'b0;
                    dbus_stb_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_db_split.sv
// tb/tb_rv_db_split.sv - scoreboard bench for rv_db_split
module tb_rv_db_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        valid_ns = 1'b0;
    logic        cmd_dbus = 1'b0;
    logic        cmd_store = 1'b0;
    logic        cmd_byte = 1'b0;
    logic        cmd_hword = 1'b0;
    logic        cmd_signed = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] dati = 32'd0;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'd0;

    logic [31:0] rdata, rdata_ns;
    logic        we, busy, misalign, fault;
    logic        we_ns, busy_ns, misalign_ns, fault_ns;
    logic        cyc, stb, dwe, cyc_ns, stb_ns, dwe_ns;
    logic [3:0]  sel, sel_ns;
    logic [29:0] adr, adr_ns;
    logic [31:0] dato, dato_ns;

    int nvec = 0;
    int nfail = 0;

    typedef struct packed {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } beat_t;

    typedef struct packed {
        logic        is_fault;
        logic [31:0] data;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    always #5 clk = ~clk;

    rv_db_split #(.SPLIT_MISALIGN(1), .TIMEOUT_CYCLES(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .cmd_dbus_i(cmd_dbus),
        .cmd_dbus_store_i(cmd_store), .cmd_dbus_byte_i(cmd_byte), .cmd_dbus_hword_i(cmd_hword),
        .cmd_signed_i(cmd_signed), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .we_o(we),
        .busy_o(busy), .misalign_o(misalign), .fault_o(fault), .dbus_cyc_o(cyc), .dbus_stb_o(stb),
        .dbus_we_o(dwe), .dbus_sel_o(sel), .dbus_adr_o(adr), .dbus_dat_o(dato),
        .dbus_ack_i(ack), .dbus_err_i(err), .dbus_dat_i(dati)
    );

    rv_db_split #(.SPLIT_MISALIGN(0), .TIMEOUT_CYCLES(0)) u_nosplit (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_ns), .cmd_dbus_i(cmd_dbus),
        .cmd_dbus_store_i(cmd_store), .cmd_dbus_byte_i(cmd_byte), .cmd_dbus_hword_i(cmd_hword),
        .cmd_signed_i(cmd_signed), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_ns), .we_o(we_ns),
        .busy_o(busy_ns), .misalign_o(misalign_ns), .fault_o(fault_ns), .dbus_cyc_o(cyc_ns),
        .dbus_stb_o(stb_ns), .dbus_we_o(dwe_ns), .dbus_sel_o(sel_ns), .dbus_adr_o(adr_ns),
        .dbus_dat_o(dato_ns), .dbus_ack_i(zero), .dbus_err_i(zero), .dbus_dat_i(zero32)
    );

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_beat(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d, input logic w);
        beat_t b;
        b.adr = a; b.sel = s; b.dat = d; b.we = w;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic f, input logic [31:0] d);
        resp_t r;
        r.is_fault = f; r.data = d;
        resp_q.push_back(r);
    endtask

    task automatic issue(input logic ns, input logic st, input logic by, input logic hw,
                         input logic sg, input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        valid = ~ns; valid_ns = ns; cmd_dbus = 1'b1;
        cmd_store = st; cmd_byte = by; cmd_hword = hw; cmd_signed = sg;
        addr = ad; wdata = wd;
        @(posedge clk);
        #1 valid = 1'b0; valid_ns = 1'b0; cmd_dbus = 1'b0;
    endtask

    // Slave response for one beat: wait for stb, insert wait states, then ack or err for one cycle
    task automatic beat(input int waits, input logic [31:0] d, input logic e);
        int n = 0;
        @(negedge clk);
        while (!stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stb_wait", {71'd0, stb}, 72'd1);
        repeat (waits) @(negedge clk);
        dati = d; ack = ~e; err = e;
        @(posedge clk);
        #1 ack = 1'b0; err = 1'b0; dati = 32'd0;
    endtask

    // Monitor: compares completing beats and load/fault responses against the queues
    always begin
        beat_t b;
        resp_t r;
        @(negedge clk);
        #4;
        if (!rst) begin
            if (stb && (ack || err)) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {5'd0, adr, sel, dato, dwe}, 72'd0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat", {5'd0, adr, sel, dato, dwe}, {5'd0, b});
                    chk("beat_cyc", {71'd0, cyc}, 72'd1);
                end
            end
            if (we || fault || misalign) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", {37'd0, we, fault, misalign, rdata}, 72'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_kind", {69'd0, we, fault, misalign}, r.is_fault ? 72'd2 : 72'd4);
                    chk("resp_rdata", {40'd0, rdata}, {40'd0, r.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("reset_outs", {26'd0, rdata, we, busy, misalign, fault, cyc, stb, dwe, sel, adr[5:0]}, 72'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Aligned word load, 0-wait: stb cycle 1, we_o cycle 2
        push_beat(30'h400, 4'b1111, 32'h0, 1'b0); push_resp(1'b0, 32'hDEAD_BEEF);
        issue(0, 0, 0, 0, 0, 32'h0000_1000, 32'h0);
        chk("lat_stb_c1", {70'd0, stb, busy}, 72'd3);
        beat(0, 32'hDEAD_BEEF, 0);
        chk("lat_we_c2", {69'd0, we, busy, cyc}, 72'd6);
        @(posedge clk); #1;
        chk("lat_idle_c3", {70'd0, we, busy}, 72'd0);

        // Signed and unsigned byte load at offset 3
        push_beat(30'h400, 4'b1000, 32'h0, 1'b0); push_resp(1'b0, 32'hFFFF_FF80);
        issue(0, 0, 1, 0, 1, 32'h0000_1003, 32'h0);
        beat(1, 32'h8000_0000, 0);
        push_beat(30'h400, 4'b1000, 32'h0, 1'b0); push_resp(1'b0, 32'h0000_0080);
        issue(0, 0, 1, 0, 0, 32'h0000_1003, 32'h0);
        beat(0, 32'h8000_0000, 0);

        // Split word load at offset 2
        push_beat(30'h400, 4'b1100, 32'h0, 1'b0); push_beat(30'h401, 4'b0011, 32'h0, 1'b0);
        push_resp(1'b0, 32'hCCDD_AABB);
        issue(0, 0, 0, 0, 0, 32'h0000_1002, 32'h0);
        beat(0, 32'hAABB_1111, 0);
        chk("split_locked", {70'd0, cyc, stb}, 72'd3);
        beat(1, 32'h2222_CCDD, 0);

        // Split hword store across the top of the address space
        push_beat(30'h3FFF_FFFF, 4'b1000, 32'h3400_0000, 1'b1);
        push_beat(30'h0, 4'b0001, 32'h0000_0012, 1'b1);
        issue(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_1234);
        beat(1, 32'h0, 0);
        beat(2, 32'h0, 0);
        chk("store_no_we", {71'd0, we}, 72'd0);

        // Hword loads: signed at offset 2, unsigned at offset 1 (fits, single beat)
        push_beat(30'h800, 4'b1100, 32'h0, 1'b0); push_resp(1'b0, 32'hFFFF_8001);
        issue(0, 0, 0, 1, 1, 32'h0000_2002, 32'h0);
        beat(0, 32'h8001_7777, 0);
        push_beat(30'h1401, 4'b0110, 32'h0, 1'b0); push_resp(1'b0, 32'h0000_ABCD);
        issue(0, 0, 0, 1, 0, 32'h0000_5005, 32'h0);
        beat(0, 32'h00AB_CD00, 0);

        // Byte store at offset 1
        push_beat(30'hC00, 4'b0010, 32'h0000_A500, 1'b1);
        issue(0, 1, 1, 0, 0, 32'h0000_3001, 32'h0000_00A5);
        beat(0, 32'h0, 0);

        // Split load with error on the second beat: fault, rdata unchanged
        push_beat(30'h400, 4'b1110, 32'h0, 1'b0); push_beat(30'h401, 4'b0001, 32'h0, 1'b0);
        push_resp(1'b1, 32'h0000_ABCD);
        issue(0, 0, 0, 0, 0, 32'h0000_1001, 32'h0);
        beat(0, 32'h1111_1111, 0);
        beat(0, 32'h2222_2222, 1);
        chk("err_cyc_drop", {70'd0, cyc, stb}, 72'd0);

        // Timeout: slave never answers, fault after 4 stb cycles
        push_resp(1'b1, 32'h0000_ABCD);
        issue(0, 0, 0, 0, 0, 32'h0000_4000, 32'h0);
        n = 0;
        while (n < 20) begin
            @(negedge clk); #4;
            if (!stb) break;
            n++;
        end
        chk("timeout_stb_cycles", 72'(n), 72'd4);
        chk("timeout_fault", {70'd0, fault, cyc}, 72'd2);

        // Request without cmd_dbus_i is ignored
        @(negedge clk);
        valid = 1'b1; addr = 32'h0000_1000;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1;
        chk("no_dbus_idle", {70'd0, cyc, busy}, 72'd0);

        // No-split instance: misaligned word and hword rejected, no bus cycle
        issue(1, 0, 0, 0, 0, 32'h0000_1001, 32'h0);
        chk("ns_misalign_word", {70'd0, misalign_ns, cyc_ns}, 72'd2);
        @(posedge clk); #1;
        chk("ns_after", {69'd0, misalign_ns, cyc_ns, busy_ns}, 72'd0);
        issue(1, 0, 0, 1, 0, 32'h0000_1003, 32'h0);
        chk("ns_misalign_hword", {70'd0, misalign_ns, cyc_ns}, 72'd2);

        // Asynchronous reset in the middle of a beat
        issue(0, 0, 0, 0, 0, 32'h0000_6000, 32'h0);
        chk("rst_pre_stb", {71'd0, stb}, 72'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_async", {38'd0, cyc, stb, busy, rdata}, 72'd0);
        @(negedge clk); rst = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("beat_q_empty", 72'(beat_q.size()), 72'd0);
        chk("resp_q_empty", 72'(resp_q.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
